// File: rtl/csr_snapshot_reader_if.sv
// Bundle between the snapshot reader, the CSR file's combinational read port and the trace consumer.
// The reader uses the master modport; the CSR file and the consumer use the slave modport.
interface csr_snapshot_reader_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
);
    logic [CSR_ADDR_WIDTH-1:0] csr_raddr;
    logic [DATA_WIDTH-1:0]     csr_rdata;
    logic                      out_valid;
    logic                      out_ready;
    logic [CSR_ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0]     out_data;
    logic                      out_last;

    modport master (
        output csr_raddr,
        input  csr_rdata,
        output out_valid,
        input  out_ready,
        output out_addr,
        output out_data,
        output out_last
    );

    modport slave (
        input  csr_raddr,
        output csr_rdata,
        input  out_valid,
        output out_ready,
        input  out_addr,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/csr_snapshot_reader.sv
// Captures mcycle/stall/taken-branch in three back-to-back CSR reads, then streams
// the (address, data) pairs out over valid/ready.
module csr_snapshot_reader #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [DROP_CNT_WIDTH-1:0] dropped_cnt_o,
    csr_snapshot_reader_if.master     bus
);
    localparam int NUM_CSR = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_STREAM  = 2'd2
    } state_t;

    state_t                    state_reg, state_next;
    logic [1:0]                idx_reg, idx_next;
    logic [DROP_CNT_WIDTH-1:0] drop_reg;
    logic                      done_reg;
    logic [DATA_WIDTH-1:0]     buf_data [NUM_CSR];
    logic [DATA_WIDTH-1:0]     beat_data;

    function automatic logic [CSR_ADDR_WIDTH-1:0] table_addr(input logic [1:0] i);
        case (i)
            2'd1:    table_addr = CSR_ADDR_WIDTH'(12'hB03);
            2'd2:    table_addr = CSR_ADDR_WIDTH'(12'hB04);
            default: table_addr = CSR_ADDR_WIDTH'(12'hB00);
        endcase
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // In STREAM out_valid is always high, so ready alone completes a beat.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_CAPTURE;
                    idx_next   = 2'd0;
                end
            end
            ST_CAPTURE: begin
                if (idx_reg == 2'd2) begin
                    state_next = ST_STREAM;
                    idx_next   = 2'd0;
                end else begin
                    idx_next = idx_reg + 2'd1;
                end
            end
            ST_STREAM: begin
                if (bus.out_ready) begin
                    if (idx_reg == 2'd2) begin
                        state_next = ST_IDLE;
                        idx_next   = 2'd0;
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = 2'd0;
            end
        endcase
    end

    always_comb begin
        beat_data = '0;
        case (idx_reg)
            2'd0:    beat_data = buf_data[0];
            2'd1:    beat_data = buf_data[1];
            2'd2:    beat_data = buf_data[2];
            default: beat_data = '0;
        endcase
    end

    always_comb begin
        busy_o        = (state_reg != ST_IDLE);
        done_o        = done_reg;
        dropped_cnt_o = drop_reg;
        bus.out_valid = (state_reg == ST_STREAM);
        bus.out_last  = (state_reg == ST_STREAM) && (idx_reg == 2'd2);
        bus.out_addr  = (state_reg == ST_STREAM) ? table_addr(idx_reg) : table_addr(2'd0);
        bus.out_data  = (state_reg == ST_STREAM) ? beat_data : '0;
        bus.csr_raddr = (state_reg == ST_CAPTURE) ? table_addr(idx_reg) : table_addr(2'd0);
    end

    // One capture register per table entry; each loads only in its own CAPTURE cycle.
    generate
        for (genvar gi = 0; gi < NUM_CSR; gi++) begin : g_buf
            logic [DATA_WIDTH-1:0] data_reg;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    data_reg <= '0;
                end else if (state_reg == ST_CAPTURE && idx_reg == 2'(gi)) begin
                    data_reg <= bus.csr_rdata;
                end
            end
            assign buf_data[gi] = data_reg;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_reg <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == ST_STREAM) && (idx_reg == 2'd2) && bus.out_ready;
            if (start_i && state_reg != ST_IDLE && drop_reg != {DROP_CNT_WIDTH{1'b1}}) begin
                drop_reg <= drop_reg + 1'b1;
            end
        end
    end
endmodule
